mult_control: RTL and testbench



---
 rtl/mult_control.sv | 130 +++++++++++++
 tb/tb_mult_control.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_control.sv
// Sequencing FSM for the shift-add signed multiplier: CLR, then N_BITS ADD/SHIFT pairs, final ADD subtracts.
// Optional MULT_SKIP_ZERO_ADD_EN: iterations whose multiplier bit is 0 spend a single shift cycle instead of two.
module mult_control #(
    parameter int N_BITS = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clear_XA,
    output logic Ld_B,
    output logic Ld_A,
    output logic Ld_X,
    output logic Shift_En,
    output logic Sub,
    output logic Busy,
    output logic Done
);

    localparam int CNT_W = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             last;
    logic             skip;

    assign last = (cnt == LAST);

    // A skipped add turns the ADD slot into the shift for that iteration,
    // so the decision sees the post-shift B[0] on the M input.
`ifdef MULT_SKIP_ZERO_ADD_EN
    assign skip = (state == ADD) && !M;
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (Run) state <= CLR;
                end
                CLR: begin
                    cnt   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    if (!skip) begin
                        state <= SHIFT;
                    end else if (last) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ADD;
                    end
                end
                DONE: begin
                    if (!Run) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Clear_XA = 1'b0;
        Ld_B     = 1'b0;
        Ld_A     = 1'b0;
        Ld_X     = 1'b0;
        Shift_En = 1'b0;
        Sub      = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: begin
                // Held quiet for the first cycle after reset release
                if (armed && ClearA_LoadB && !Run) begin
                    Ld_B     = 1'b1;
                    Clear_XA = 1'b1;
                end
            end
            CLR: begin
                Clear_XA = 1'b1;
                Busy     = 1'b1;
            end
            ADD: begin
                Busy = 1'b1;
                if (skip) begin
                    Shift_En = 1'b1;
                end else begin
                    Ld_A = M;
                    Ld_X = M;
                    Sub  = last;
                end
            end
            SHIFT: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
            end
            DONE: begin
                Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// Randomized self-checking bench for mult_control: a per-run schedule of expected
// output vectors is built from the multiplier bits and compared every cycle.
module tb_mult_control;

    localparam int N = 8;

    logic Clk = 1'b0;
    logic Reset, Run, ClearA_LoadB, M;
    logic Clear_XA, Ld_B, Ld_A, Ld_X, Shift_En, Sub, Busy, Done;

    mult_control #(.N_BITS(N)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .Clear_XA(Clear_XA), .Ld_B(Ld_B), .Ld_A(Ld_A), .Ld_X(Ld_X),
        .Shift_En(Shift_En), .Sub(Sub), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mode;            // 0 idle, 1 multiplying, 2 result held
    bit rel;             // first cycle after a reset release
    logic [8:0] q[$];    // {m, Clear_XA, Ld_B, Ld_A, Ld_X, Shift_En, Sub, Busy, Done}
    logic [N-1:0] cur_b;
    int c_lda, c_sh, c_busy, c_sub, c_ldb, sub_idx;

    function automatic logic rbit();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    function automatic logic [8:0] mk(input logic m, input logic clr, input logic lda,
                                      input logic sh, input logic sub);
        return {m, clr, 1'b0, lda, lda, sh, sub, 1'b1, 1'b0};
    endfunction

    function automatic void build(input logic [N-1:0] b);
        q.delete();
        q.push_back(mk(b[0], 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < N; i++) begin
`ifdef MULT_SKIP_ZERO_ADD_EN
            if (!b[i]) begin
                q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            end else begin
                q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, i == N - 1));
                q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
            end
`else
            q.push_back(mk(b[i], 1'b0, b[i], 1'b0, i == N - 1));
            q.push_back(mk(b[i], 1'b0, 1'b0, 1'b1, 1'b0));
`endif
        end
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic clr_counts();
        c_lda = 0; c_sh = 0; c_busy = 0; c_sub = 0; c_ldb = 0; sub_idx = -1;
    endtask

    // Called at posedge+1 with Run/ClearA_LoadB already driven; compares at the falling edge.
    task automatic step();
        logic [7:0] exp, got;
        if (mode == 1) M = q[0][8];
        else M = rbit();
        #4;
        if (rel) exp = 8'b0;
        else if (mode == 0) exp = {ClearA_LoadB && !Run, ClearA_LoadB && !Run, 6'b0};
        else if (mode == 1) exp = q[0][7:0];
        else exp = 8'b0000_0001;
        got = {Clear_XA, Ld_B, Ld_A, Ld_X, Shift_En, Sub, Busy, Done};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL outputs cyc=%0d mode=%0d got=%b want=%b", cyc, mode, got, exp);
        end
        c_lda  += int'(Ld_A);
        c_sh   += int'(Shift_En);
        c_ldb  += int'(Ld_B);
        c_busy += int'(Busy);
        if (Sub) begin
            c_sub++;
            sub_idx = c_busy - 1;
        end
        rel = 1'b0;
        if (mode == 0 && Run) begin
            build(cur_b);
            mode = 1;
        end else if (mode == 1) begin
            void'(q.pop_front());
            if (q.size() == 0) mode = 2;
        end else if (mode == 2 && !Run) begin
            mode = 0;
        end
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic do_run(input logic [N-1:0] b, input int hold);
        int guard;
        cur_b = b;
        clr_counts();
        Run = 1'b1;
        ClearA_LoadB = 1'b1;
        step();
        guard = 0;
        while (mode == 1 && guard < 100) begin
            Run = rbit();
            ClearA_LoadB = rbit();
            step();
            guard++;
        end
        chk("run_completes", mode, 2);
        Run = 1'b1;
        repeat (hold) begin
            ClearA_LoadB = rbit();
            step();
        end
        Run = 1'b0;
        step();
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            int'({Clear_XA, Ld_B, Ld_A, Ld_X, Shift_En, Sub, Busy, Done}), 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        mode = 0;
        q.delete();
        rel = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
        mode = 0; rel = 1'b0; cur_b = '0;
        clr_counts();
        #12;
        chk("reset_hold_outputs",
            int'({Clear_XA, Ld_B, Ld_A, Ld_X, Shift_En, Sub, Busy, Done}), 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        rel = 1'b1;
        ClearA_LoadB = 1'b1;
        step();

        // Load/clear while idle: exactly as many pulses as cycles held
        clr_counts();
        ClearA_LoadB = 1'b1;
        repeat (3) step();
        ClearA_LoadB = 1'b0;
        step();
        chk("ldb_pulses", c_ldb, 3);
        chk("idle_busy", c_busy, 0);

        // All multiplier bits set
        do_run(8'hFF, 3);
        chk("ff_lda", c_lda, 8);
        chk("ff_shift", c_sh, 8);
        chk("ff_busy", c_busy, 17);
        chk("ff_sub_count", c_sub, 1);
        chk("ff_sub_cycle", sub_idx, 15);

        // All multiplier bits clear
        do_run(8'h00, 2);
        chk("zero_lda", c_lda, 0);
        chk("zero_shift", c_sh, 8);
`ifdef MULT_SKIP_ZERO_ADD_EN
        chk("zero_busy", c_busy, 9);
        chk("zero_sub", c_sub, 0);
`else
        chk("zero_busy", c_busy, 17);
        chk("zero_sub", c_sub, 1);
`endif

        // B=0x05 with Run held 50 cycles after completion: no retrigger
        do_run(8'h05, 50);
        chk("b05_lda", c_lda, 2);
        chk("b05_shift", c_sh, 8);
`ifdef MULT_SKIP_ZERO_ADD_EN
        chk("b05_busy", c_busy, 11);
        chk("b05_sub", c_sub, 0);
`else
        chk("b05_busy", c_busy, 17);
        chk("b05_sub", c_sub, 1);
`endif
        // Run dropped for one cycle above, raised again here
        do_run(8'h81, 1);
        chk("b81_lda", c_lda, 2);

        // Reset in the middle of a run, while adding with cnt=3
        cur_b = 8'hFF;
        Run = 1'b1;
        ClearA_LoadB = 1'b0;
        step();
        repeat (7) begin
            Run = rbit();
            step();
        end
        M = 1'b1;
        pulse_reset();
        Run = 1'b0;
        ClearA_LoadB = 1'b1;
        step();
        do_run(8'hFF, 1);
        chk("restart_busy", c_busy, 17);

        // Random operands interleaved with random idle activity
        repeat (8) begin
            r = $urandom;
            Run = 1'b0;
            repeat (int'(r[11:10])) begin
                ClearA_LoadB = rbit();
                step();
            end
            do_run(r[N-1:0], int'(r[9:8]));
            chk("rand_shift", c_sh, 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
